decoder_3_to_8: RTL and testbench

- Registered binary-to-one-hot decoder: 3-bit select in, 8-bit one-hot out, gated by an enable.
- Used wherever a binary index must drive per-line selects (chip selects, write-enable fan-out, mux controls).
- The output is registered on one clock with an asynchronous active-high reset.
- Decoder width is parameterised; the defaults give the 3-to-8 configuration.

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/decoder_3_to_8_core.sv | 32 +++
 rtl/decoder_3_to_8.sv | 59 +++++
 tb/tb_decoder_3_to_8.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths and the reference binary-to-one-hot decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package decoder_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    function automatic logic [DEC_OUT_W-1:0] onehot_decode(
        input logic [DEC_IN_W-1:0] value,
        input logic                enable
    );
        logic [DEC_OUT_W-1:0] w_code;
        w_code = '0;
        if (enable) begin
            w_code[value] = 1'b1;
        end
        return w_code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_3_to_8_core.sv
// ============================================================================
// Module      : decoder_3_to_8_core
// Description : Pure combinational binary-to-one-hot decode gated by en.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module decoder_3_to_8_core
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  din,
    input  logic             en,
    output logic [OUT_W-1:0] next_dout
);

    // The default geometry reuses the shared reference function; other widths
    // fall back to a per-line compare.
    if (IN_W == DEC_IN_W && OUT_W == DEC_OUT_W) begin : g_pkg_decode
        assign next_dout = onehot_decode(din, en);
    end else begin : g_generic_decode
        for (genvar i = 0; i < OUT_W; i++) begin : g_line
            assign next_dout[i] = en && (din == IN_W'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/decoder_3_to_8.sv
// ============================================================================
// Module      : decoder_3_to_8
// Description : Registered one-hot decoder with enable and output-valid flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module decoder_3_to_8
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  din,
    input  logic             en,
    output logic [OUT_W-1:0] dout,
    output logic             dout_vld
);

    if (OUT_W != 2**IN_W) begin : g_width_check
        $fatal(1, "decoder_3_to_8: OUT_W must equal 2**IN_W");
    end

    logic [OUT_W-1:0] w_next_dout;
    logic [OUT_W-1:0] r_dout;
    logic             r_dout_vld;

    decoder_3_to_8_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .din       (din),
        .en        (en),
        .next_dout (w_next_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout     <= w_next_dout;
            r_dout_vld <= en;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

    a_onehot_when_valid : assert property (
        @(posedge clk) disable iff (rst) dout_vld |-> $onehot(dout)
    ) else $error("decoder_3_to_8: dout not one-hot while dout_vld=1");

endmodule

`default_nettype wire

// File: tb/tb_decoder_3_to_8.sv
// ============================================================================
// Module      : tb_decoder_3_to_8
// Description : Directed and random checks of the registered one-hot decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_decoder_3_to_8;
    import decoder_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] din;
    logic       en;
    logic [7:0] dout;
    logic       dout_vld;

    int err_cnt;
    int chk_cnt;

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                  8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3_to_8 #(
        .IN_W  (3),
        .OUT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .en       (en),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%02h expected=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev_din;
        logic       prev_en;

        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        en  = 1'b1;
        din = 3'b111;

        // Reset held with en=1, din=7: outputs zero before any clock edge.
        #2;
        check_val("rst_dout_noclk", dout, 8'h00);
        check_val("rst_vld_noclk", {7'b0, dout_vld}, 8'h00);
        tick();
        tick();
        check_val("rst_dout_held", dout, 8'h00);
        rst = 1'b0;
        tick();
        check_val("rel_dout", dout, 8'h80);
        check_val("rel_vld", {7'b0, dout_vld}, 8'h01);

        // Asynchronous clear from a non-zero state, between edges.
        rst = 1'b1;
        #1;
        check_val("async_dout", dout, 8'h00);
        check_val("async_vld", {7'b0, dout_vld}, 8'h00);
        rst = 1'b0;
        tick();
        check_val("rel2_dout", dout, 8'h80);

        // Full sweep.
        for (int d = 0; d < 8; d++) begin
            din = 3'(d);
            en  = 1'b1;
            tick();
            check_val($sformatf("sweep_dout_%0d", d), dout, sweep_exp[d]);
            check_val($sformatf("sweep_vld_%0d", d), {7'b0, dout_vld}, 8'h01);
        end

        // Disable then re-enable.
        en  = 1'b0;
        din = 3'b101;
        tick();
        check_val("dis_dout", dout, 8'h00);
        check_val("dis_vld", {7'b0, dout_vld}, 8'h00);
        en = 1'b1;
        tick();
        check_val("reen_dout", dout, 8'h20);
        check_val("reen_vld", {7'b0, dout_vld}, 8'h01);

        // en toggling with din constant.
        din = 3'b011;
        for (int k = 0; k < 6; k++) begin
            en = (k % 2 == 0);
            tick();
            check_val($sformatf("tog_dout_%0d", k), dout, (k % 2 == 0) ? 8'h08 : 8'h00);
            check_val($sformatf("tog_vld_%0d", k), {7'b0, dout_vld}, (k % 2 == 0) ? 8'h01 : 8'h00);
        end

        // Mid-stream reset while sweeping.
        en = 1'b1;
        for (int d = 0; d < 4; d++) begin
            din = 3'(d);
            tick();
        end
        check_val("mid_pre_dout", dout, 8'h08);
        din = 3'b100;
        rst = 1'b1;
        #1;
        check_val("mid_async_dout", dout, 8'h00);
        check_val("mid_async_vld", {7'b0, dout_vld}, 8'h00);
        #1;
        rst = 1'b0;
        tick();
        check_val("mid_rel_dout", dout, 8'h10);
        check_val("mid_rel_vld", {7'b0, dout_vld}, 8'h01);
        din = 3'b101;
        tick();
        check_val("mid_next_dout", dout, 8'h20);

        // Random stream against the reference decode of the previous inputs.
        for (int n = 0; n < 1000; n++) begin
            din = 3'($urandom_range(0, 7));
            en  = 1'($urandom_range(0, 1));
            prev_din = din;
            prev_en  = en;
            tick();
            check_val("rand_dout", dout, onehot_decode(prev_din, prev_en));
            check_val("rand_vld", {7'b0, dout_vld}, {7'b0, prev_en});
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
